// File: rtl/ser_par_pkg.sv
// Shared types for the serial/parallel link.
//   s2p_state_t : two-state FSM used by both serializer and deserializer
//   cnt_w(n)    : width of a counter that runs 0..n-1
package ser_par_pkg;

  typedef enum logic {COLLECT, FULL} s2p_state_t;

  // Never returns less than 1, so N=2 still gets a real 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_to_par_obuf.sv
// One-word valid/ready holding register for the deserializer output.
//   clk, rst      : clock, async active-high reset
//   load_i        : capture load_data_i and mark the buffer valid
//   load_data_i   : word to capture
//   par_ready_i   : downstream consumes the held word
//   par_data_o    : held word (stable while valid and not consumed)
//   par_valid_o   : buffer holds an unconsumed word
//   free_o        : buffer can accept a load this edge
module ser_to_par_obuf #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] load_data_i,
  input  logic         par_ready_i,
  output logic [N-1:0] par_data_o,
  output logic         par_valid_o,
  output logic         free_o
);

  logic [N-1:0] data_q;
  logic         valid_q;

  assign free_o      = !valid_q | par_ready_i;
  assign par_data_o  = data_q;
  assign par_valid_o = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= load_data_i;
      valid_q <= 1'b1;
    end else if (valid_q && par_ready_i) begin
      // Consumed with nothing new: drop valid, data keeps its last value.
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ser_to_par.sv
// Serial-to-parallel deserializer. Collects N bits over a valid/ready
// handshake into sreg, then hands the word to a one-entry output buffer.
// While the buffer is occupied a second word may complete in sreg; the
// FSM then parks in FULL (ser_ready low) until the buffer frees up.
//   clk, rst             : clock, async active-high reset
//   ser_data/ser_valid   : serial bit input
//   ser_ready            : a bit is accepted this cycle (state decode only)
//   par_data/par_valid   : assembled word output
//   par_ready            : downstream consumes par_data
module ser_to_par
  import ser_par_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_data,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready
);

  localparam int CNT_W = cnt_w(N);

  s2p_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     sreg_q, sreg_d;
  logic             accept, last, free, load;
  logic [N-1:0]     load_data;

  assign ser_ready = (state_q == COLLECT);
  assign accept    = ser_valid & ser_ready;
  assign last      = (cnt_q == CNT_W'(N - 1));

  // LSB-first shifts in at the top so bit 0 ends up at sreg[0].
  assign sreg_d = MSB_FIRST ? {sreg_q[N-2:0], ser_data}
                            : {ser_data, sreg_q[N-1:1]};

  // COLLECT loads the word completing this edge (including the new bit);
  // FULL drains the word parked in sreg.
  assign load      = (state_q == FULL) ? free : (accept & last & free);
  assign load_data = (state_q == FULL) ? sreg_q : sreg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            sreg_q <= sreg_d;
            if (last) begin
              cnt_q <= '0;
              if (!free) state_q <= FULL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        FULL: begin
          // cnt already wrapped to 0 when the word completed.
          if (free) state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  ser_to_par_obuf #(.N(N)) u_obuf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_data_i (load_data),
    .par_ready_i (par_ready),
    .par_data_o  (par_data),
    .par_valid_o (par_valid),
    .free_o      (free)
  );

endmodule

// File: tb/tb_ser_to_par.sv
module tb_ser_to_par;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_data = 1'b0;
  logic       ser_valid = 1'b0;
  logic       par_ready = 1'b0;
  logic       ser_ready, par_valid;
  logic [7:0] par_data;
  logic       ser_ready_m, par_valid_m;
  logic [7:0] par_data_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ser_to_par #(.N(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .par_data(par_data), .par_valid(par_valid),
    .par_ready(par_ready)
  );

  ser_to_par #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(ser_ready_m), .par_data(par_data_m), .par_valid(par_valid_m),
    .par_ready(par_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back LSB-first word; caller guarantees ser_ready stays high.
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      ser_data  = w[i];
      ser_valid = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
  endtask

  // Async reset pulse mid-cycle with immediate output checks.
  task automatic pulse_rst(input string tag);
    ser_valid = 1'b0;
    par_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_ser_ready"}, ser_ready, 1);
    check({tag, "_par_valid"}, par_valid, 0);
    check({tag, "_par_data"},  par_data,  8'h00);
    #1 rst = 1'b0;
    tick();
  endtask

  logic [7:0] words4 [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] wq [100];

  initial begin
    #1;
    check("rst_ser_ready", ser_ready, 1);
    check("rst_par_valid", par_valid, 0);
    check("rst_par_data",  par_data,  8'h00);
    tick(); tick();
    rst = 1'b0;

    // LSB-first / MSB-first: bits 1,0,1,1,0,0,1,0
    par_ready = 1'b1;
    begin
      logic [7:0] w;
      w = 8'h4D;
      for (int i = 0; i < 8; i++) begin
        ser_data  = w[i];
        ser_valid = 1'b1;
        tick();
        if (i < 7) check("lsb_early_valid", par_valid, 0);
      end
    end
    ser_valid = 1'b0;
    check("lsb_valid", par_valid, 1);
    check("lsb_data",  par_data, 8'h4D);
    check("msb_valid", par_valid_m, 1);
    check("msb_data",  par_data_m, 8'hB2);
    check("msb_ser_ready", ser_ready_m, 1);
    tick();
    check("lsb_valid_one_cycle", par_valid, 0);
    check("lsb_data_kept", par_data, 8'h4D);

    // Back-pressure
    pulse_rst("bp_rst");
    par_ready = 1'b0;
    send_word(8'hA5);
    check("bp_w1_valid", par_valid, 1);
    check("bp_w1_data",  par_data, 8'hA5);
    check("bp_w1_ser_ready", ser_ready, 1);
    send_word(8'h3C);
    check("bp_full_ser_ready", ser_ready, 0);
    check("bp_full_data", par_data, 8'hA5);
    tick();
    check("bp_full_hold", ser_ready, 0);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    check("bp_p1_data", par_data, 8'h3C);
    check("bp_p1_valid", par_valid, 1);
    check("bp_p1_ser_ready", ser_ready, 1);
    tick();
    check("bp_p1_stable", par_data, 8'h3C);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    check("bp_p2_valid", par_valid, 0);
    check("bp_p2_data_kept", par_data, 8'h3C);

    // Seamless handoff
    pulse_rst("ho_rst");
    par_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) begin
        ser_data  = words4[w][i];
        ser_valid = 1'b1;
        tick();
        check("ho_ser_ready", ser_ready, 1);
        if (i == 7) begin
          check("ho_valid", par_valid, 1);
          check("ho_data", par_data, {24'h0, words4[w]});
        end else begin
          check("ho_idle", par_valid, 0);
        end
      end
    end
    ser_valid = 1'b0;

    // Reset mid-word and in FULL
    pulse_rst("rw_rst0");
    par_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ser_data  = 1'b1;
      ser_valid = 1'b1;
      tick();
    end
    pulse_rst("rw_mid");
    par_ready = 1'b1;
    send_word(8'h96);
    check("rw_mid_valid", par_valid, 1);
    check("rw_mid_data", par_data, 8'h96);
    tick();
    par_ready = 1'b0;
    send_word(8'hFF);
    send_word(8'hFF);
    check("rw_full_state", ser_ready, 0);
    pulse_rst("rw_full");
    par_ready = 1'b1;
    send_word(8'h5A);
    check("rw_full_valid", par_valid, 1);
    check("rw_full_data", par_data, 8'h5A);

    // Random gaps on both sides, scoreboarded
    pulse_rst("gap_rst");
    for (int i = 0; i < 100; i++) wq[i] = 8'($urandom);
    begin
      int         sb, rx, cyc;
      logic       hold, consume, accept;
      logic [7:0] hold_data;
      sb = 0; rx = 0; cyc = 0; hold = 1'b0; hold_data = '0;
      while (rx < 100 && cyc < 6000) begin
        cyc++;
        if (hold) begin
          check("gap_hold_valid", par_valid, 1);
          check("gap_hold_data", par_data, hold_data);
        end
        par_ready = 1'($urandom_range(0, 1));
        if (sb < 800) begin
          ser_valid = 1'($urandom_range(0, 1));
          ser_data  = wq[sb / 8][sb % 8];
        end else begin
          ser_valid = 1'b0;
        end
        consume = par_valid & par_ready;
        accept  = ser_valid & ser_ready;
        if (consume) begin
          check("gap_word", par_data, wq[rx]);
          rx++;
        end
        hold      = par_valid & !par_ready;
        hold_data = par_data;
        tick();
        if (accept) sb++;
      end
      check("gap_count", rx, 100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ser_to_par.md
# ser_to_par

Serial-to-parallel deserializer: the receiving end of the team's parallel-to-serial link. It accepts one bit per `ser_valid`/`ser_ready` handshake and assembles `N` bits into a word, LSB-first by default. Each completed word is presented on a `par_valid`/`par_ready` interface through a one-word output buffer, so the next word can be collected while the current one waits. The block sits directly downstream of a serializer, or of any single-bit valid/ready source.

## Interface
- `N`, default 8: word width in bits, N ≥ 2.
- `MSB_FIRST`, default 0: 0 means the first received bit lands in `par_data[0]`; 1 means it lands in `par_data[N-1]`.

- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `ser_data` input 1: serial bit.
- `ser_valid` input 1: `ser_data` is valid.
- `ser_ready` output 1: block accepts a bit this cycle.
- `par_data` output N: assembled word.
- `par_valid` output 1: `par_data` holds an unconsumed word.
- `par_ready` input 1: downstream consumes `par_data`.

## Operation
- A bit is accepted on any posedge with `ser_valid & ser_ready`. A word is consumed on any posedge with `par_valid & par_ready`.
- State machine, two states:
  - COLLECT: `ser_ready` = 1.
  - FULL: `ser_ready` = 0.
- `ser_ready` is a pure decode of the state. It has no combinational path from `ser_valid` or `par_ready`.
- Shift register `sreg[N-1:0]`:
  - `MSB_FIRST` = 0: on each accepted bit, `sreg <= {ser_data, sreg[N-1:1]}`.
  - `MSB_FIRST` = 1: on each accepted bit, `sreg <= {sreg[N-2:0], ser_data}`.
- Bit counter `cnt` is `$clog2(N)` bits wide and runs 0..N-1. It increments on each accepted bit and wraps to 0 on the Nth bit.
- Nth bit accepted (`cnt` == N-1):
  - If the buffer is empty, or is being consumed on the same edge: load the completed word (including this bit) into `par_data`, set `par_valid`, stay in COLLECT.
  - Otherwise: the completed word stays in `sreg` and the FSM moves to FULL.
- In FULL, on the first edge where the buffer is consumed:
  - `par_data <= sreg`, `par_valid` stays 1.
  - FSM returns to COLLECT, `cnt` = 0.
- Buffer consumed with no new word arriving: `par_valid <= 0`. `par_data` keeps its old value.
- While `par_valid` = 1, `par_data` is stable until consumed.
- No bit is ever dropped or duplicated. Words are delivered in arrival order.

## Timing
- Reset values, asserted asynchronously:
  - State COLLECT, so `ser_ready` = 1.
  - `cnt` = 0, `sreg` = 0.
  - `par_valid` = 0, `par_data` = 0.
- Reset mid-word discards the partial word. Reset with a word pending discards that word. The first bit after reset release is bit 0 of a new word.
- Latency: if the Nth bit is accepted at edge k, `par_valid` is 1 in the cycle after edge k.
- Throughput: with `ser_valid` and `par_ready` held high, one word every N cycles with no bubbles, and `ser_ready` never drops.
- Back-pressure: two words in flight at most. With `par_ready` = 0, `ser_ready` falls one cycle after the second word completes.
- A consume and an Nth bit on the same edge is a seamless handoff, not a stall.
- `ser_valid` = 0 mid-word holds `sreg` and `cnt`. There is no timeout.

## Structure
- Package `ser_par_pkg` holds:
  - `typedef enum logic {COLLECT, FULL} s2p_state_t`, shared with the serializer's state type.
  - A helper constant for the counter width, `CNT_W = $clog2(N)`, provided as a parameterized function `cnt_w(n)`.
- One sub-module: `ser_to_par_obuf`, the N-bit valid/ready holding register.
  - Ports: load, load data, `par_*`.
  - Exports `free = !par_valid | par_ready`, used by the FSM.
- The top level holds the FSM, `cnt` and `sreg`.

## Test plan
All scenarios use N=8 unless stated.
- **LSB-first word:** with `MSB_FIRST`=0 and `par_ready`=1, send bits 1,0,1,1,0,0,1,0 on consecutive cycles -> `par_data` = 8'h4D, `par_valid` high for exactly 1 cycle, starting the cycle after the 8th bit.
- **MSB-first word:** with `MSB_FIRST`=1, send the same bits -> `par_data` = 8'hB2.
- **Back-pressure:** hold `par_ready`=0 and stream 0xA5 then 0x3C continuously.
  - `ser_ready` drops the cycle after the 16th bit; `par_data` stays 0xA5.
  - Pulse `par_ready` for 1 cycle -> `par_data` becomes 0x3C, `ser_ready` returns to 1 the next cycle.
  - Pulse again -> `par_valid`=0.
- **Seamless handoff:** stream 4 words 0x01, 0x80, 0xFF, 0x00 with `par_ready`=1 -> 4 words out in order, 8 cycles apart, `ser_ready` constantly 1.
- **Gaps:** randomize `ser_valid` gaps (duty about 50%) over 100 words, checked against a scoreboard model -> exact word sequence, and `par_data` stable whenever `par_valid` & !`par_ready`.
- **Reset mid-operation:** pulse `rst` after 5 bits of a word, and again while in FULL -> all outputs at reset values immediately. The next 8 bits form a clean new word, with no residue from the old one.
